countdown_timer: RTL and testbench

Countdown stage of the microwave timer path. Takes the three BCD digits assembled by the keypad timer-input stage (minutes, tens of seconds, units of seconds) and counts them down to 0:00 at one step per TICK_DIV clocks under start/stop/clear control. It drives the display digits, the magnetron enable and a done indication consumed by the alarm/display stages.

---
 rtl/countdown_timer.sv | 137 +++++++++++++
 tb/tb_countdown_timer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Microwave countdown stage: counts loaded BCD M:SS down to 0:00, one step per TICK_DIV clocks.
// Optional door interlock is compiled in with `define DOOR_INTERLOCK_EN.
module countdown_timer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] load_min,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_units,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
`ifdef DOOR_INTERLOCK_EN
    input  logic       door_open,
`endif
    output logic [3:0] min_digit,
    output logic [3:0] tens_digit,
    output logic [3:0] units_digit,
    output logic       mag_on,
    output logic       done
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [3:0]       min_q, min_d, tens_q, tens_d, units_q, units_d;
    logic             mag_on_q, mag_on_d, done_q, done_d;
    logic [11:0]      load_clamped, dec_val;
    logic             door_w;

`ifdef DOOR_INTERLOCK_EN
    assign door_w = door_open;
`else
    assign door_w = 1'b0;
`endif

    function automatic logic [3:0] sat_digit(input logic [3:0] v, input logic [3:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    // One-second BCD decrement with borrow; 0:00 stays at 0:00.
    function automatic logic [11:0] dec_time(input logic [3:0] m, input logic [3:0] t,
                                             input logic [3:0] u);
        logic [3:0] m_n, t_n, u_n;
        m_n = m;
        t_n = t;
        u_n = u;
        if (u != 4'd0) begin
            u_n = u - 4'd1;
        end else if (t != 4'd0) begin
            u_n = 4'd9;
            t_n = t - 4'd1;
        end else if (m != 4'd0) begin
            u_n = 4'd9;
            t_n = 4'd5;
            m_n = m - 4'd1;
        end
        return {m_n, t_n, u_n};
    endfunction

    assign load_clamped = {sat_digit(load_min, 4'd9), sat_digit(load_tens, 4'd5),
                           sat_digit(load_units, 4'd9)};
    assign dec_val      = dec_time(min_q, tens_q, units_q);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        min_d   = min_q;
        tens_d  = tens_q;
        units_d = units_q;
        case (state_q)
            IDLE: begin
                {min_d, tens_d, units_d} = load_clamped;
                if (!stop && start && !door_w && (load_clamped != 12'h000)) begin
                    state_d = RUN;
                    pre_d   = '0;
                end
            end
            RUN: begin
                if (stop || door_w) begin
                    state_d = PAUSE;
                end else if (pre_q == PRE_MAX) begin
                    pre_d = '0;
                    {min_d, tens_d, units_d} = dec_val;
                    if (dec_val == 12'h000) state_d = DONE;
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            PAUSE: begin
                if (!stop && start && !door_w) state_d = RUN;
            end
            default: ;
        endcase
        if (clear) begin
            state_d = IDLE;
            pre_d   = '0;
            min_d   = 4'd0;
            tens_d  = 4'd0;
            units_d = 4'd0;
        end
        mag_on_d = (state_d == RUN);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            min_q    <= 4'd0;
            tens_q   <= 4'd0;
            units_q  <= 4'd0;
            mag_on_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            min_q    <= min_d;
            tens_q   <= tens_d;
            units_q  <= units_d;
            mag_on_q <= mag_on_d;
            done_q   <= done_d;
        end
    end

    assign min_digit   = min_q;
    assign tens_digit  = tens_q;
    assign units_digit = units_q;
    assign mag_on      = mag_on_q;
    assign done        = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4; interlock vectors run when DOOR_INTERLOCK_EN is defined.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] load_min, load_tens, load_units;
    logic       start, stop, clear;
    logic       door_open;
    logic [3:0] min_digit, tens_digit, units_digit;
    logic       mag_on, done;
    logic [11:0] dig;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_min   (load_min),
        .load_tens  (load_tens),
        .load_units (load_units),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
`ifdef DOOR_INTERLOCK_EN
        .door_open  (door_open),
`endif
        .min_digit  (min_digit),
        .tens_digit (tens_digit),
        .units_digit(units_digit),
        .mag_on     (mag_on),
        .done       (done)
    );

    always #5 clk = ~clk;
    assign dig = {min_digit, tens_digit, units_digit};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic set_load(input logic [3:0] m, input logic [3:0] t, input logic [3:0] u);
        load_min   = m;
        load_tens  = t;
        load_units = u;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        clear = 1'b0;
        door_open = 1'b0;
        set_load(4'd0, 4'd1, 4'd2);
        @(negedge clk);
        step(1);
        check("rst_digits", dig, 12'h000);
        check("rst_mag", mag_on, 1'b0);
        check("rst_done", done, 1'b0);

        rst = 1'b0;
        step(1);
        check("first_reload", dig, 12'h012);

        // Basic countdown from 0:12
        pulse_start();
        check("start_mag", mag_on, 1'b1);
        step(3);
        check("pre_tick", dig, 12'h012);
        step(1);
        check("tick1", dig, 12'h011);
        step(4);
        check("tick2", dig, 12'h010);
        step(4);
        check("tick3", dig, 12'h009);
        step(35);
        check("done_early", done, 1'b0);
        check("mag_before_done", mag_on, 1'b1);
        step(1);
        check("done_at_48", done, 1'b1);
        check("mag_at_done", mag_on, 1'b0);
        check("digits_at_done", dig, 12'h000);
        start = 1'b1;
        stop = 1'b1;
        step(1);
        start = 1'b0;
        stop = 1'b0;
        check("done_holds", done, 1'b1);
        check("done_no_mag", mag_on, 1'b0);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clear_done", done, 1'b0);
        check("clear_digits", dig, 12'h000);
        step(1);
        check("reload_after_clear", dig, 12'h012);

        // Borrow chain from 1:00
        set_load(4'd1, 4'd0, 4'd0);
        step(1);
        pulse_start();
        step(4);
        check("borrow", dig, 12'h059);
        step(235);
        check("borrow_last", dig, 12'h001);
        check("borrow_not_done", done, 1'b0);
        step(1);
        check("borrow_done", done, 1'b1);
        check("borrow_zero", dig, 12'h000);
        clear = 1'b1;
        step(1);
        clear = 1'b0;

        // Clamping and zero start
        set_load(4'd12, 4'd7, 4'd15);
        step(1);
        check("clamp", dig, 12'h959);
        set_load(4'd0, 4'd0, 4'd0);
        step(1);
        pulse_start();
        check("zero_start_mag", mag_on, 1'b0);
        check("zero_start_dig", dig, 12'h000);
        step(1);
        check("zero_start_mag2", mag_on, 1'b0);

        // Pause and resume, stop two cycles into a period
        set_load(4'd0, 4'd0, 4'd5);
        step(1);
        pulse_start();
        step(2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("pause_mag", mag_on, 1'b0);
        set_load(4'd0, 4'd0, 4'd9);
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("pause_frozen", dig, 12'h005);
        end
        pulse_start();
        check("resume_mag", mag_on, 1'b1);
        step(1);
        check("resume_wait", dig, 12'h005);
        step(1);
        check("resume_tick", dig, 12'h004);

        // Stop coinciding with a prescaler wrap
        step(3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("wrap_stop_dig", dig, 12'h004);
        check("wrap_stop_mag", mag_on, 1'b0);
        pulse_start();
        check("wrap_resume_dig", dig, 12'h004);
        step(1);
        check("pending_tick", dig, 12'h003);

        // Clear mid-run at 0:30
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        set_load(4'd0, 4'd3, 4'd0);
        step(1);
        pulse_start();
        check("run_30", mag_on, 1'b1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clear_run_dig", dig, 12'h000);
        check("clear_run_mag", mag_on, 1'b0);
        set_load(4'd0, 4'd4, 4'd7);
        step(1);
        check("clear_live_load", dig, 12'h047);

        // stop outranks start in IDLE
        start = 1'b1;
        stop = 1'b1;
        step(1);
        start = 1'b0;
        stop = 1'b0;
        check("stop_over_start", mag_on, 1'b0);

        // Asynchronous reset between edges
        pulse_start();
        step(4);
        check("pre_async", dig, 12'h046);
        #2 rst = 1'b1;
        #1;
        check("async_dig", dig, 12'h000);
        check("async_mag", mag_on, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        check("post_rst_reload", dig, 12'h047);

`ifdef DOOR_INTERLOCK_EN
        pulse_start();
        door_open = 1'b1;
        step(1);
        check("door_pause", mag_on, 1'b0);
        start = 1'b1;
        step(1);
        check("door_start_ignored", mag_on, 1'b0);
        door_open = 1'b0;
        step(1);
        start = 1'b0;
        check("door_resume", mag_on, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
